// File: rtl/sparse_mult_by_at_pkg.sv
// Shared types and defaults for the sparse multiply blocks (forward and transpose).
package sparse_mult_by_at_pkg;

   localparam int unsigned DEFAULT_WIDTH = 96;
   localparam int unsigned BLOCK_LENGTH  = 11;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_PING,
      ST_PONG,
      ST_WAIT_FOR_PING,
      ST_WAIT_FOR_PONG
   } states_t;

endpackage

// File: rtl/sparse_mult_by_at_if.sv
// Input and output stream handshake bundle for sparse_mult_by_at.
interface sparse_mult_by_at_if
   import sparse_mult_by_at_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
);

   logic [WIDTH-1:0] i_input_data;
   logic             i_input_valid;
   logic             o_input_ready;
   logic [WIDTH-1:0] o_output_data;
   logic             o_output_valid;
   logic             i_output_ready;
   logic             o_output_last;

   // Upstream producer / downstream consumer side
   modport master (
      output i_input_data,
      output i_input_valid,
      input  o_input_ready,
      input  o_output_data,
      input  o_output_valid,
      output i_output_ready,
      input  o_output_last
   );

   // Block side
   modport slave (
      input  i_input_data,
      input  i_input_valid,
      output o_input_ready,
      output o_output_data,
      output o_output_valid,
      input  i_output_ready,
      output o_output_last
   );

endinterface

// File: rtl/sparse_pingpong_slot.sv
// One-word holding buffer with a full flag; load and release never hit the same slot together.
module sparse_pingpong_slot
   import sparse_mult_by_at_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             load,
   input  logic [WIDTH-1:0] data_in,
   input  logic             release_en,
   output logic [WIDTH-1:0] data_out,
   output logic             full
);

   // Capture the word on load, drop the full flag on release
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         data_out <= '0;
         full     <= 1'b0;
      end else if (load) begin
         data_out <= data_in;
         full     <= 1'b1;
      end else if (release_en) begin
         full     <= 1'b0;
      end
   end

endmodule

// File: rtl/sparse_mult_by_at.sv
// Upsampler: each input word becomes OUTPUT_LENGTH-1 zero words followed by the word itself.
module sparse_mult_by_at
   import sparse_mult_by_at_pkg::*;
#(
   parameter int unsigned WIDTH         = DEFAULT_WIDTH,
   parameter int unsigned OUTPUT_LENGTH = BLOCK_LENGTH
) (
   input  logic            i_clock,
   input  logic            i_reset,
   sparse_mult_by_at_if.slave bus
);

   localparam int unsigned     CNT_W      = $clog2(OUTPUT_LENGTH);
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(OUTPUT_LENGTH - 1);

   states_t          fill_state;
   states_t          rd_state;
   logic [CNT_W-1:0] out_count;

   logic             ping_full;
   logic             pong_full;
   logic [WIDTH-1:0] ping_data;
   logic [WIDTH-1:0] pong_data;

   logic target_full;
   logic input_ready;
   logic in_fire;
   logic load_ping;
   logic load_pong;
   logic reading;
   logic at_last;
   logic out_fire;
   logic block_done;
   logic release_ping;
   logic release_pong;

   // Fill-side handshake: accept only into the buffer the fill pointer targets, when empty
   assign target_full = (fill_state == ST_PONG) ? pong_full : ping_full;
   assign input_ready = (fill_state != ST_INIT) && !target_full;
   assign in_fire     = bus.i_input_valid && input_ready;
   assign load_ping   = in_fire && (fill_state == ST_PING);
   assign load_pong   = in_fire && (fill_state == ST_PONG);

   // Readout-side handshake and end-of-block release
   assign reading      = (rd_state == ST_PING) || (rd_state == ST_PONG);
   assign at_last      = (out_count == LAST_COUNT);
   assign out_fire     = reading && bus.i_output_ready;
   assign block_done   = out_fire && at_last;
   assign release_ping = block_done && (rd_state == ST_PING);
   assign release_pong = block_done && (rd_state == ST_PONG);

   // Outputs decoded purely from registered state so they hold under backpressure
   assign bus.o_input_ready  = input_ready;
   assign bus.o_output_valid = reading;
   assign bus.o_output_last  = reading && at_last;
   assign bus.o_output_data  = (reading && at_last)
                               ? ((rd_state == ST_PONG) ? pong_data : ping_data)
                               : '0;

   sparse_pingpong_slot #(.WIDTH(WIDTH)) u_ping (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .load       (load_ping),
      .data_in    (bus.i_input_data),
      .release_en (release_ping),
      .data_out   (ping_data),
      .full       (ping_full)
   );

   sparse_pingpong_slot #(.WIDTH(WIDTH)) u_pong (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .load       (load_pong),
      .data_in    (bus.i_input_data),
      .release_en (release_pong),
      .data_out   (pong_data),
      .full       (pong_full)
   );

   // Fill FSM: alternate target buffer after every accepted word
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         fill_state <= ST_INIT;
      end else begin
         case (fill_state)
            ST_INIT: fill_state <= ST_PING;
            ST_PING: if (in_fire) fill_state <= ST_PONG;
            ST_PONG: if (in_fire) fill_state <= ST_PING;
            default: fill_state <= ST_INIT;
         endcase
      end
   end

   // Readout FSM: stream one block per full buffer, hop straight to the other if it is ready
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         rd_state  <= ST_INIT;
         out_count <= '0;
      end else begin
         case (rd_state)
            ST_INIT: rd_state <= ST_WAIT_FOR_PING;
            ST_WAIT_FOR_PING: if (ping_full) rd_state <= ST_PING;
            ST_WAIT_FOR_PONG: if (pong_full) rd_state <= ST_PONG;
            ST_PING: begin
               if (out_fire) begin
                  if (at_last) begin
                     out_count <= '0;
                     rd_state  <= pong_full ? ST_PONG : ST_WAIT_FOR_PONG;
                  end else begin
                     out_count <= out_count + CNT_W'(1);
                  end
               end
            end
            ST_PONG: begin
               if (out_fire) begin
                  if (at_last) begin
                     out_count <= '0;
                     rd_state  <= ping_full ? ST_PING : ST_WAIT_FOR_PING;
                  end else begin
                     out_count <= out_count + CNT_W'(1);
                  end
               end
            end
            default: begin
               rd_state  <= ST_INIT;
               out_count <= '0;
            end
         endcase
      end
   end

endmodule
